// File: rtl/uart_pixel_cmd.sv
// UART pixel command decoder: parses 8-byte SYNC/X/Y/COLOR/CHK frames from a byte
// stream and issues one framebuffer write per valid frame over a valid/ready handshake.
module uart_pixel_cmd #(
    parameter int unsigned H_RES          = 640,
    parameter int unsigned V_RES          = 480,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        data_valid,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [9:0]  wr_x,
    output logic [8:0]  wr_y,
    output logic [11:0] wr_color,
    output logic [7:0]  err_cnt,
    output logic [1:0]  last_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_CHK   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_OVR   = 2'd3;

    localparam logic [3:0] ST_HUNT  = 4'd0;
    localparam logic [3:0] ST_XH    = 4'd1;
    localparam logic [3:0] ST_XL    = 4'd2;
    localparam logic [3:0] ST_YH    = 4'd3;
    localparam logic [3:0] ST_YL    = 4'd4;
    localparam logic [3:0] ST_CH    = 4'd5;
    localparam logic [3:0] ST_CL    = 4'd6;
    localparam logic [3:0] ST_CHK   = 4'd7;
    localparam logic [3:0] ST_ISSUE = 4'd8;

    logic [3:0]    state;
    logic [3:0]    state_nxt;
    logic          dv_q;
    logic [15:0]   x_q;
    logic [15:0]   y_q;
    logic [11:0]   c_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] to_cnt;

    logic       accept_c;
    logic       in_frame_c;
    logic       timeout_c;
    logic       range_ok_c;
    logic       err_c;
    logic [1:0] err_code_c;
    logic       load_c;
    logic       clr_wr_c;

    // Rising edge of data_valid marks a new byte, so long strobes count once.
    assign accept_c   = data_valid && !dv_q;
    assign in_frame_c = (state >= ST_XH) && (state <= ST_CHK);
    assign timeout_c  = in_frame_c && !accept_c && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign range_ok_c = (32'(x_q) < H_RES) && (32'(y_q) < V_RES);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt  = state;
        err_c      = 1'b0;
        err_code_c = 2'd0;
        load_c     = 1'b0;
        clr_wr_c   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (accept_c && byte_data == SYNC_BYTE) begin
                    state_nxt = ST_XH;
                end
            end
            ST_XH, ST_XL, ST_YH, ST_YL, ST_CH, ST_CL: begin
                if (accept_c) begin
                    state_nxt = state + 4'd1;
                end else if (timeout_c) begin
                    state_nxt  = ST_HUNT;
                    err_c      = 1'b1;
                    err_code_c = ERR_OVR;
                end
            end
            ST_CHK: begin
                if (accept_c) begin
                    state_nxt = ST_HUNT;
                    if (byte_data != chk_q) begin
                        err_c      = 1'b1;
                        err_code_c = ERR_CHK;
                    end else if (!range_ok_c) begin
                        err_c      = 1'b1;
                        err_code_c = ERR_RANGE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        load_c    = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_nxt  = ST_HUNT;
                    err_c      = 1'b1;
                    err_code_c = ERR_OVR;
                end
            end
            ST_ISSUE: begin
                // A byte arriving with the handshake belongs to the next frame.
                if (wr_valid && wr_ready) begin
                    clr_wr_c  = 1'b1;
                    state_nxt = (accept_c && byte_data == SYNC_BYTE) ? ST_XH : ST_HUNT;
                end else if (accept_c) begin
                    err_c      = 1'b1;
                    err_code_c = ERR_OVR;
                end
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    // Frame capture, running checksum and inter-byte timer
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q   <= 1'b0;
            x_q    <= 16'd0;
            y_q    <= 16'd0;
            c_q    <= 12'd0;
            chk_q  <= 8'd0;
            to_cnt <= '0;
        end else begin
            dv_q <= data_valid;
            if (accept_c) begin
                case (state)
                    ST_XH: begin
                        x_q[15:8] <= byte_data;
                        chk_q     <= byte_data;
                    end
                    ST_XL: begin
                        x_q[7:0] <= byte_data;
                        chk_q    <= chk_q ^ byte_data;
                    end
                    ST_YH: begin
                        y_q[15:8] <= byte_data;
                        chk_q     <= chk_q ^ byte_data;
                    end
                    ST_YL: begin
                        y_q[7:0] <= byte_data;
                        chk_q    <= chk_q ^ byte_data;
                    end
                    ST_CH: begin
                        c_q[11:8] <= byte_data[3:0];
                        chk_q     <= chk_q ^ byte_data;
                    end
                    ST_CL: begin
                        c_q[7:0] <= byte_data;
                        chk_q    <= chk_q ^ byte_data;
                    end
                    default: begin
                    end
                endcase
            end
            if (accept_c || !in_frame_c) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Write request outputs and error reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_x     <= 10'd0;
            wr_y     <= 9'd0;
            wr_color <= 12'd0;
            err_cnt  <= 8'd0;
            last_err <= 2'd0;
        end else begin
            if (load_c) begin
                wr_valid <= 1'b1;
                wr_x     <= x_q[9:0];
                wr_y     <= y_q[8:0];
                wr_color <= c_q;
            end else if (clr_wr_c) begin
                wr_valid <= 1'b0;
            end
            if (err_c) begin
                last_err <= err_code_c;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_cmd.sv
// Directed bench for uart_pixel_cmd: valid, corrupt, out-of-range and stalled frames,
// timeouts, long strobes, reset mid-frame and error counter saturation.
module tb_uart_pixel_cmd;

    localparam int unsigned TO = 40;

    localparam logic [63:0] F_OK     = 64'hA5_01_23_00_F0_0A_BC_64;
    localparam logic [63:0] F_BADCHK = 64'hA5_01_23_00_F0_0A_BC_65;
    localparam logic [63:0] F_XRANGE = 64'hA5_02_80_00_10_00_0F_9D;
    localparam logic [63:0] F_YRANGE = 64'hA5_00_10_01_E0_00_00_F1;
    localparam logic [63:0] F_BOTH   = 64'hA5_02_80_00_10_00_0F_9C;
    localparam logic [63:0] F_EDGE   = 64'hA5_02_7F_01_DF_F5_3C_6A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_data = 8'd0;
    logic        data_valid = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [11:0] wr_color;
    logic [7:0]  err_cnt;
    logic [1:0]  last_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int stab_viol = 0;
    int base;
    logic        pend = 1'b0;
    logic [9:0]  px = '0, cap_x = '0;
    logic [8:0]  py = '0, cap_y = '0;
    logic [11:0] pc = '0, cap_c = '0;

    uart_pixel_cmd #(.H_RES(640), .V_RES(480), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data),
        .data_valid(data_valid),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color),
        .err_cnt   (err_cnt),
        .last_err  (last_err)
    );

    always #5 clk = ~clk;

    // Handshake log and hold-stability watch while a write is stalled
    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend && (!wr_valid || wr_x != px || wr_y != py || wr_color != pc))
                stab_viol <= stab_viol + 1;
            pend <= wr_valid && !wr_ready;
            px <= wr_x;
            py <= wr_y;
            pc <= wr_color;
            if (wr_valid && wr_ready) begin
                wr_cnt <= wr_cnt + 1;
                cap_x  <= wr_x;
                cap_y  <= wr_y;
                cap_c  <= wr_color;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        byte_data  = b;
        data_valid = 1'b1;
        repeat (hold) @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] f, input int hold);
        for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then idle in HUNT must not time out
        do_reset();
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_x",     32'(wr_x),     32'd0);
        check("rst_wr_y",     32'(wr_y),     32'd0);
        check("rst_wr_color", 32'(wr_color), 32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_last_err", 32'(last_err), 32'd0);
        repeat (TO + 20) @(negedge clk);
        check("hunt_no_timeout", 32'(err_cnt), 32'd0);

        // Basic frame, one-cycle write latency
        base = wr_cnt;
        send_frame(F_OK, 1);
        check("ok_valid", 32'(wr_valid), 32'd1);
        check("ok_x",     32'(wr_x),     32'h123);
        check("ok_y",     32'(wr_y),     32'h0F0);
        check("ok_color", 32'(wr_color), 32'hABC);
        @(negedge clk);
        check("ok_done",  32'(wr_valid), 32'd0);
        check("ok_cnt",   32'(wr_cnt),   32'(base + 1));
        check("ok_err",   32'(err_cnt),  32'd0);

        // Checksum error then edge-of-range valid frame
        send_frame(F_BADCHK, 1);
        repeat (2) @(negedge clk);
        check("chk_nowr",  32'(wr_cnt),   32'(base + 1));
        check("chk_last",  32'(last_err), 32'd1);
        check("chk_cnt",   32'(err_cnt),  32'd1);
        send_frame(F_EDGE, 1);
        @(negedge clk);
        check("edge_cnt",   32'(wr_cnt), 32'(base + 2));
        check("edge_x",     32'(cap_x),  32'h27F);
        check("edge_y",     32'(cap_y),  32'h1DF);
        check("edge_color", 32'(cap_c),  32'h53C);
        check("edge_err",   32'(err_cnt), 32'd1);

        // Range failures and checksum priority
        do_reset();
        base = wr_cnt;
        send_frame(F_XRANGE, 1);
        repeat (2) @(negedge clk);
        check("xr_last", 32'(last_err), 32'd2);
        check("xr_cnt",  32'(err_cnt),  32'd1);
        send_frame(F_YRANGE, 1);
        repeat (2) @(negedge clk);
        check("yr_last", 32'(last_err), 32'd2);
        check("yr_cnt",  32'(err_cnt),  32'd2);
        send_frame(F_BOTH, 1);
        repeat (2) @(negedge clk);
        check("both_last", 32'(last_err), 32'd1);
        check("both_cnt",  32'(err_cnt),  32'd3);
        check("range_nowr", 32'(wr_cnt), 32'(base));

        // Inter-byte timeout, trailing bytes ignored until next sync
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        repeat (TO - 10) @(negedge clk);
        check("to_early", 32'(err_cnt), 32'd0);
        repeat (20) @(negedge clk);
        check("to_last", 32'(last_err), 32'd3);
        check("to_cnt",  32'(err_cnt),  32'd1);
        for (int i = 2; i < 8; i++) send_byte(F_OK[63-8*i -: 8], 1);
        repeat (2) @(negedge clk);
        check("to_tail_nowr", 32'(wr_cnt),  32'(base));
        check("to_tail_err",  32'(err_cnt), 32'd1);
        send_frame(F_OK, 1);
        @(negedge clk);
        check("to_recover", 32'(wr_cnt), 32'(base + 1));

        // Stalled write with an overrun byte
        do_reset();
        base = wr_cnt;
        wr_ready = 1'b0;
        send_frame(F_OK, 1);
        check("stall_valid", 32'(wr_valid), 32'd1);
        repeat (10) @(negedge clk);
        send_byte(8'h11, 1);
        repeat (38) @(negedge clk);
        check("stall_hold",  32'(wr_valid), 32'd1);
        check("stall_x",     32'(wr_x),     32'h123);
        check("stall_color", 32'(wr_color), 32'hABC);
        check("stall_last",  32'(last_err), 32'd3);
        check("stall_err",   32'(err_cnt),  32'd1);
        check("stall_nowr",  32'(wr_cnt),   32'(base));
        wr_ready = 1'b1;
        @(negedge clk);
        check("stall_done",  32'(wr_valid), 32'd0);
        check("stall_wr",    32'(wr_cnt),   32'(base + 1));

        // Sync byte on the handshake cycle starts a new frame without error
        do_reset();
        base = wr_cnt;
        wr_ready = 1'b0;
        send_frame(F_OK, 1);
        repeat (3) @(negedge clk);
        wr_ready   = 1'b1;
        byte_data  = 8'hA5;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("hs_first", 32'(wr_cnt), 32'(base + 1));
        for (int i = 1; i < 8; i++) send_byte(F_EDGE[63-8*i -: 8], 1);
        @(negedge clk);
        check("hs_second", 32'(wr_cnt),  32'(base + 2));
        check("hs_x",      32'(cap_x),   32'h27F);
        check("hs_err",    32'(err_cnt), 32'd0);
        check("hs_last",   32'(last_err), 32'd0);

        // Long strobes, then reset mid-frame
        base = wr_cnt;
        send_frame(F_EDGE, 3);
        @(negedge clk);
        check("long_cnt", 32'(wr_cnt),  32'(base + 1));
        check("long_y",   32'(cap_y),   32'h1DF);
        check("long_err", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(F_OK[63-8*i -: 8], 3);
        do_reset();
        check("mid_rst_err",  32'(err_cnt),  32'd0);
        check("mid_rst_last", 32'(last_err), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(F_OK[63-8*i -: 8], 3);
        repeat (2) @(negedge clk);
        check("mid_rst_nowr", 32'(wr_cnt),  32'(base + 1));
        check("mid_rst_err2", 32'(err_cnt), 32'd0);
        send_frame(F_OK, 3);
        @(negedge clk);
        check("mid_rst_wr", 32'(wr_cnt), 32'(base + 2));
        check("mid_rst_x",  32'(cap_x),  32'h123);

        // Error counter saturation, then reset drops the pending write
        do_reset();
        wr_ready = 1'b0;
        send_frame(F_OK, 1);
        for (int i = 0; i < 260; i++) send_byte(8'h11, 1);
        @(negedge clk);
        check("sat_cnt",   32'(err_cnt),  32'd255);
        check("sat_last",  32'(last_err), 32'd3);
        check("sat_valid", 32'(wr_valid), 32'd1);
        base = wr_cnt;
        do_reset();
        check("rst_pend_valid", 32'(wr_valid), 32'd0);
        check("rst_pend_err",   32'(err_cnt),  32'd0);
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pend_nowr", 32'(wr_cnt), 32'(base));

        check("hold_stable", 32'(stab_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
